tdpr_copy_engine: RTL

//  Initiator for the true dual-port RAM: drives both RAM ports to move a block of words.

---
 rtl/tdpr_copy_engine.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tdpr_copy_engine.sv
// Copy/fill engine that drives both ports of a true dual-port RAM.
// COPY streams words from src (port A reads) to dst (port B writes) at one
// word per cycle. FILL writes a captured constant to dst on port B only.
module tdpr_copy_engine #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_SIZE-1:0] src_addr,
    input  logic [ADDR_SIZE-1:0] dst_addr,
    input  logic [ADDR_SIZE:0]   len,
    input  logic [DATA_SIZE-1:0] fill_val,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic                   en_a_q,  en_a_d;
    logic                   en_b_q,  en_b_d;
    logic                   we_b_q,  we_b_d;
    logic [ADDR_SIZE-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_SIZE-1:0]   addr_b_q, addr_b_d;
    logic [ADDR_SIZE-1:0]   dst_q,   dst_d;
    logic [ADDR_SIZE:0]     len_q,   len_d;
    // Number of words already issued (reads in COPY, writes in FILL).
    logic [ADDR_SIZE:0]     cnt_q,   cnt_d;
    logic [DATA_SIZE-1:0]   fill_q,  fill_d;

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        en_a_d   = en_a_q;
        en_b_d   = en_b_q;
        we_b_d   = we_b_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        dst_d    = dst_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        // Empty transfer: acknowledge without touching the RAM.
                        done_d = 1'b1;
                    end else begin
                        dst_d  = dst_addr;
                        len_d  = len;
                        fill_d = fill_val;
                        cnt_d  = {{ADDR_SIZE{1'b0}}, 1'b1};
                        busy_d = 1'b1;
                        if (!mode) begin
                            state_d  = S_COPY;
                            en_a_d   = 1'b1;
                            addr_a_d = src_addr;
                        end else begin
                            state_d  = S_FILL;
                            en_b_d   = 1'b1;
                            we_b_d   = 1'b1;
                            addr_b_d = dst_addr;
                        end
                    end
                end
            end

            S_COPY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    en_a_d  = 1'b0;
                    en_b_d  = 1'b0;
                    we_b_d  = 1'b0;
                end else begin
                    // Read side: keep issuing reads until len words requested.
                    if (cnt_q < len_q) begin
                        en_a_d   = 1'b1;
                        addr_a_d = addr_a_q + 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        en_a_d = 1'b0;
                    end
                    // Write side trails the read side by one cycle; the read
                    // issued last cycle returns now on dout_a.
                    if (en_a_q) begin
                        en_b_d   = 1'b1;
                        we_b_d   = 1'b1;
                        addr_b_d = en_b_q ? addr_b_q + 1'b1 : dst_q;
                    end else begin
                        en_b_d  = 1'b0;
                        we_b_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    en_a_d  = 1'b0;
                    en_b_d  = 1'b0;
                    we_b_d  = 1'b0;
                end else if (cnt_q < len_q) begin
                    addr_b_d = addr_b_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    en_b_d  = 1'b0;
                    we_b_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                en_a_d  = 1'b0;
                en_b_d  = 1'b0;
                we_b_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_a_q   <= 1'b0;
            en_b_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_a_q   <= en_a_d;
            en_b_q   <= en_b_d;
            we_b_q   <= we_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
        end
    end

    // Port B data: RAM read data in COPY (no extra pipeline stage), fill constant in FILL.
    always_comb begin
        din_b = '0;
        case (state_q)
            S_COPY:  din_b = dout_a;
            S_FILL:  din_b = fill_q;
            default: din_b = '0;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign en_a   = en_a_q;
    assign we_a   = 1'b0;
    assign addr_a = addr_a_q;
    assign din_a  = '0;
    assign en_b   = en_b_q;
    assign we_b   = we_b_q;
    assign addr_b = addr_b_q;

endmodule
